// File: rtl/iob_mem_arbiter.sv
// Two-master round-robin arbiter onto one shared memory port; one transaction in flight.
// Latency: request registered into s_* on the edge after valid, ready returns combinationally with s_ready.
// Backpressure: the losing master is held with ready=0 until the owner completes, for any number of cycles.
module iob_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,

    output logic [1:0]          grant,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              last_q, last_d;   // 1: master 1 was granted most recently
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic pick_m1;
    logic done;

    // Master 1 wins if it is alone, or if both ask and master 0 went last.
    assign pick_m1 = m1_valid & (~m0_valid | ~last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (state_q == IDLE) begin
            if (m0_valid || m1_valid) begin
                state_d = BUSY;
                last_d  = pick_m1;
                grant_d = pick_m1 ? 2'b10 : 2'b01;
                addr_d  = pick_m1 ? m1_addr  : m0_addr;
                wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
            end
        end else if (s_ready) begin
            state_d = IDLE;
            grant_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // s_ready outside BUSY is ignored, so a stray response never reaches a master.
    assign done     = (state_q == BUSY) & s_ready;
    assign m0_ready = done & grant_q[0];
    assign m1_ready = done & grant_q[1];
    assign m0_rdata = grant_q[0] ? s_rdata : '0;
    assign m1_rdata = grant_q[1] ? s_rdata : '0;

    assign s_valid  = (state_q == BUSY);
    assign busy     = (state_q == BUSY);
    assign grant    = grant_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;

endmodule

// File: doc/iob_mem_arbiter.md
IOB_MEM_ARBITER -- requirements
Module: iob_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; the strobe width is DATA_W/8.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 m0_valid, m1_valid  input  1 each  SHALL be the requester valids, held high with fields stable until the matching ready.
REQ-006 m0_addr, m1_addr  input  ADDR_W each  SHALL carry the request address.
REQ-007 m0_wdata, m1_wdata  input  DATA_W each  SHALL carry the write data.
REQ-008 m0_wstrb, m1_wstrb  input  DATA_W/8 each  SHALL carry the byte strobes; nonzero means write, zero means read.
REQ-009 m0_rdata, m1_rdata  output  DATA_W each  SHALL return the read data.
REQ-010 m0_ready, m1_ready  output  1 each  SHALL be a one-cycle completion pulse.
REQ-011 s_valid, s_addr, s_wdata, s_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  SHALL form the shared external-memory request.
REQ-012 s_rdata, s_ready  input  DATA_W/1  SHALL form the shared memory response.
REQ-013 grant  output  2  SHALL be one-hot, identifying the master owning the slave; 00 when idle.
REQ-014 busy  output  1  SHALL be high while a transaction is outstanding.

Function
REQ-015 The FSM SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE with any valid high, the block SHALL select one winner per REQ-018, then on the next edge latch its addr/wdata/wstrb into s_* registers, set s_valid=1, grant=winner, busy=1, and enter BUSY.
REQ-017 In IDLE with no valid high, all outputs SHALL hold their idle values.
REQ-018 Arbitration SHALL be round-robin with a 1-bit last-grant register: when both masters are valid, the master not granted last SHALL win; when one master is valid, it SHALL win regardless of history.
REQ-019 The last-grant register SHALL update only on entry to BUSY.
REQ-020 In BUSY, s_valid and s_* fields SHALL remain stable until s_ready=1.
REQ-021 In the cycle s_ready=1, the granted master's ready SHALL be driven high combinationally and its rdata SHALL equal s_rdata; the other master's ready SHALL stay 0.
REQ-022 On the edge ending that cycle, the FSM SHALL return to IDLE with s_valid=0, grant=00, busy=0.
REQ-023 Only one transaction SHALL be outstanding; the non-granted master SHALL be stalled with ready=0 for any duration.
REQ-024 s_ready while in IDLE SHALL be ignored, with no ready pulse and no state change.
REQ-025 A master that drops valid while granted SHALL NOT abort the transaction; completion SHALL still pulse its ready.
REQ-026 A master re-asserting valid the cycle after its ready SHALL be arbitrated normally in IDLE; under contention it SHALL lose to the other master.
REQ-027 Minimum latency SHALL be 2 cycles from valid high in IDLE to ready, achieved when s_ready returns in the first BUSY cycle.
REQ-028 m*_rdata SHALL be s_rdata when that master is granted and 0 otherwise.

Reset
REQ-029 While rst_n=0, all of the following SHALL hold regardless of clk: FSM=IDLE, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, grant=00, busy=0, and last-grant=master 1, so that master 0 wins the first contention.
REQ-030 Reset asserted in BUSY SHALL abandon the transaction immediately, with no ready pulse issued after rst_n is deasserted.

Verification
REQ-031 Single read: m0_valid with addr=0x100 and wstrb=0; s_ready=1 with s_rdata=0xDEADBEEF two cycles later -> s_addr=0x100 and m0_ready pulses one cycle with m0_rdata=0xDEADBEEF.
REQ-032 Contention after reset: m0 and m1 valid in the same cycle -> grant=01 first, then grant=10, then with both still requesting grant=01; no back-to-back repeat.
REQ-033 Stall: m0 granted with s_ready delayed 10 cycles while m1_valid is high -> s_* stable for 10 cycles, m1_ready=0 throughout, then m1 served next.
REQ-034 Write: m1 with addr=0x2000, wdata=0x12345678, wstrb=0xF -> s_wstrb=0xF and s_wdata=0x12345678 exactly once; m1_ready pulses once.
REQ-035 Reset mid-op: rst_n low during BUSY -> s_valid=0, busy=0, grant=00 immediately; no ready after release; the next request is served normally.
REQ-036 Spurious s_ready in IDLE -> no ready pulse and no state change.
